alu_issue: RTL
==============

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter WORD_WIDTH, default taken from parameters.v, is the datapath width and SHALL match the alu instance.
REQ-002 clk  in  1  sole clock, all state on posedge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 instr_valid  in  1; instr_ready  out  1: instruction handshake, transfer on valid&&ready at posedge.
REQ-005 instr_op  in  3  ALU_* opcode; instr_rd, instr_rs1, instr_rs2  in  3 each  register indices.
REQ-006 instr_imm_en  in  1; instr_imm  in  WORD_WIDTH: when imm_en=1, imm replaces rs2 operand.
REQ-007 alu_op  out  3; alu_in1, alu_in2  out  WORD_WIDTH: registered drive to downstream alu.
REQ-008 alu_out  in  WORD_WIDTH  alu result, valid one cycle after alu inputs.
REQ-009 wb_valid  out  1; wb_rd  out  3; wb_data  out  WORD_WIDTH: writeback strobe for the current cycle.
REQ-010 dbg_rs  in  3; dbg_data  out  WORD_WIDTH: combinational register-file read for test.

Function
REQ-011 Eight WORD_WIDTH registers r0..r7; r0 SHALL always read 0; writes to r0 SHALL be discarded.
REQ-012 Two pipeline slots SHALL be tracked: S1 (operands on alu_* outputs) and S2 (alu computing, result on alu_out), each with valid bit and rd.
REQ-013 Accept at cycle N: alu_op/in1/in2 SHALL be registered at end of N, S1 valid in N+1, S2 valid in N+2.
REQ-014 While S2 valid: wb_valid=1, wb_rd=S2.rd, wb_data=alu_out, and register rd SHALL be written at end of that cycle.
REQ-015 Latency accept-to-wb_valid SHALL be exactly 2 cycles; sustained throughput one instruction per cycle when no hazard.
REQ-016 Hazard: instr_ready SHALL be 0 when instr_valid=1 and a used source (rs1; rs2 if imm_en=0) equals S1.rd, S1 valid, S1.rd!=0.
REQ-017 Forwarding: a used source equal to S2.rd (S2 valid, rd!=0) SHALL take alu_out instead of the register file, no stall.
REQ-018 S1 match SHALL take priority over S2 match (stall); a stall SHALL last exactly one cycle.
REQ-019 instr_ready SHALL be combinational from instr fields and slot state; otherwise 1 outside reset.
REQ-020 When no accept occurs, S1 SHALL become invalid next cycle; alu_* outputs SHALL hold previous values.
REQ-021 dbg_data SHALL show register-file contents only (no forwarding); r0 reads 0.
REQ-022 Opcode semantics (add, sub, mul, slt, and, or, xor, shift) belong to alu; this block SHALL not decode them.

Reset
REQ-023 During reset: instr_ready=0; S1/S2 valid cleared; wb_valid=0; in-flight results SHALL NOT be written.
REQ-024 After reset: r0..r7=0; alu_op=ALU_ADD; alu_in1=alu_in2=0; wb_rd=0.
REQ-025 Reset mid-operation SHALL discard both slots; first accept allowed the cycle after reset deasserts.

Structure
REQ-026 WORD_WIDTH, ALU_* opcodes and register count/index width SHALL live in shared parameters.v.
REQ-027 Register file SHALL be a sub-module regfile: 2 combinational read ports plus dbg port, 1 synchronous write port, r0 hardwired zero.
REQ-028 alu SHALL be instantiated outside this block (sibling), connected via alu_* and alu_out.

Verification
REQ-029 Reset, then ADD r1=r0+imm 5 accepted at N -> wb_valid at N+2, wb_rd=1, wb_data=5; dbg r1=5 at N+3.
REQ-030 ADD r1=imm 5 then SUB r2=r1-imm 2 offered next cycle -> instr_ready=0 one cycle, then accepted; r2=3.
REQ-031 ADD r1=imm 7, unrelated ADD r5=imm 1, ADD r3=r1+r1 on consecutive cycles -> no stall (forward), r3=14.
REQ-032 ADD r0=r0+imm 9 -> wb_valid=1, wb_rd=0; dbg r0 remains 0.
REQ-033 Accept ADD r4=imm 3, assert reset next cycle -> no wb_valid; r4=0 after reset.
REQ-034 Four independent instructions back-to-back -> four consecutive wb_valid cycles, correct rd/data each, ready never low.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg -- shared definitions for the ALU issue slice.
//   WORD_WIDTH_DEF : default datapath width (must match the sibling alu)
//   NUM_REGS / REG_IDX_W : register count and index width
//   alu_op_e       : ALU opcode encodings (decoded only by the alu)
//   slot_t         : pipeline slot record (valid + destination register)
//   src_hit()      : true when a source index matches a live, non-r0 slot
package alu_issue_pkg;

  localparam int unsigned WORD_WIDTH_DEF = 32;
  localparam int unsigned NUM_REGS       = 8;
  localparam int unsigned REG_IDX_W      = 3;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_MUL   = 3'd2,
    ALU_SLT   = 3'd3,
    ALU_AND   = 3'd4,
    ALU_OR    = 3'd5,
    ALU_XOR   = 3'd6,
    ALU_SHIFT = 3'd7
  } alu_op_e;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
  } slot_t;

  // r0 never produces a hazard or a forward: it always reads zero.
  function automatic logic src_hit(input reg_idx_t rs, input slot_t s);
    return s.valid && (s.rd != '0) && (rs == s.rd);
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// alu_issue_regfile -- 8-entry register file, r0 hardwired to zero.
//   clk, reset            : clock, synchronous active-high reset (clears all)
//   raddr1/rdata1         : combinational read port 1
//   raddr2/rdata2         : combinational read port 2
//   dbg_raddr/dbg_rdata   : combinational debug read port
//   we, waddr, wdata      : synchronous write port (writes to r0 dropped)
module alu_issue_regfile
  import alu_issue_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_IDX_W-1:0]  raddr1,
  input  logic [REG_IDX_W-1:0]  raddr2,
  input  logic [REG_IDX_W-1:0]  dbg_raddr,
  output logic [WORD_WIDTH-1:0] rdata1,
  output logic [WORD_WIDTH-1:0] rdata2,
  output logic [WORD_WIDTH-1:0] dbg_rdata,
  input  logic                  we,
  input  logic [REG_IDX_W-1:0]  waddr,
  input  logic [WORD_WIDTH-1:0] wdata
);

  logic [WORD_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1    = (raddr1    == '0) ? '0 : regs[raddr1];
    rdata2    = (raddr2    == '0) ? '0 : regs[raddr2];
    dbg_rdata = (dbg_raddr == '0) ? '0 : regs[dbg_raddr];
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue -- in-order issue stage driving a sibling alu.
//   clk, reset                      : clock, synchronous active-high reset
//   instr_valid/instr_ready         : instruction handshake
//   instr_op, instr_rd/rs1/rs2      : opcode and register indices
//   instr_imm_en, instr_imm         : immediate replaces rs2 operand when set
//   alu_op, alu_in1, alu_in2        : registered operands to the alu
//   alu_out                         : alu result, one cycle after alu_* inputs
//   wb_valid, wb_rd, wb_data        : writeback strobe for the current cycle
//   dbg_rs, dbg_data                : raw register-file read (no forwarding)
// Slot S1 holds the instruction whose operands are on alu_*; slot S2 holds
// the one whose result is on alu_out and is written back this cycle.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [2:0]            instr_op,
  input  logic [REG_IDX_W-1:0]  instr_rd,
  input  logic [REG_IDX_W-1:0]  instr_rs1,
  input  logic [REG_IDX_W-1:0]  instr_rs2,
  input  logic                  instr_imm_en,
  input  logic [WORD_WIDTH-1:0] instr_imm,
  output logic [2:0]            alu_op,
  output logic [WORD_WIDTH-1:0] alu_in1,
  output logic [WORD_WIDTH-1:0] alu_in2,
  input  logic [WORD_WIDTH-1:0] alu_out,
  output logic                  wb_valid,
  output logic [REG_IDX_W-1:0]  wb_rd,
  output logic [WORD_WIDTH-1:0] wb_data,
  input  logic [REG_IDX_W-1:0]  dbg_rs,
  output logic [WORD_WIDTH-1:0] dbg_data
);

  slot_t                 s1, s2;
  logic [WORD_WIDTH-1:0] rf_rs1, rf_rs2;
  logic [WORD_WIDTH-1:0] op1, op2;
  logic                  hazard, accept;

  alu_issue_regfile #(.WORD_WIDTH(WORD_WIDTH)) regfile (
    .clk       (clk),
    .reset     (reset),
    .raddr1    (instr_rs1),
    .raddr2    (instr_rs2),
    .dbg_raddr (dbg_rs),
    .rdata1    (rf_rs1),
    .rdata2    (rf_rs2),
    .dbg_rdata (dbg_data),
    .we        (wb_valid),
    .waddr     (wb_rd),
    .wdata     (wb_data)
  );

  // S1's result is not yet available anywhere, so a dependent instruction
  // waits one cycle; by then the producer sits in S2 and is forwarded.
  always_comb begin
    hazard = instr_valid &&
             (src_hit(instr_rs1, s1) || (!instr_imm_en && src_hit(instr_rs2, s1)));
    instr_ready = !reset && !hazard;
    accept      = instr_valid && instr_ready;

    op1 = src_hit(instr_rs1, s2) ? alu_out : rf_rs1;
    if (instr_imm_en)                op2 = instr_imm;
    else if (src_hit(instr_rs2, s2)) op2 = alu_out;
    else                             op2 = rf_rs2;
  end

  // Gated by reset so an in-flight result is never committed while reset is high.
  always_comb begin
    wb_valid = s2.valid && !reset;
    wb_rd    = s2.rd;
    wb_data  = alu_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      alu_op  <= ALU_ADD;
      alu_in1 <= '0;
      alu_in2 <= '0;
    end else begin
      s2 <= s1;
      if (accept) begin
        s1.valid <= 1'b1;
        s1.rd    <= instr_rd;
        alu_op   <= instr_op;
        alu_in1  <= op1;
        alu_in2  <= op2;
      end else begin
        s1.valid <= 1'b0;
      end
    end
  end

endmodule
